// File: rtl/coeff_pkg.sv
// Shared types and helpers for the double-buffered coefficient bank.
package coeff_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Address width, never narrower than one bit so NUM==1 still has a port.
  function automatic int addr_w(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/coeff_reg_cell.sv
// One coefficient register: async active-high clear and load enable.
module coeff_reg_cell #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  logic [BITS-1:0] val_d;
  logic [BITS-1:0] val_q;

  always_comb begin
    val_d = en ? d : val_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/coeff_shadow_bank.sv
// Shadow/active coefficient bank: handshake writes land in shadow cells,
// and the whole set is copied into the active cells on a sync-aligned commit.
module coeff_shadow_bank
  import coeff_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int NUM    = 7,
  parameter int ADDR_W = addr_w(NUM)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BITS-1:0]   wr_data,
  input  logic              commit_req,
  input  logic              commit_abort,
  input  logic              sync,
  output logic              commit_done,
  output logic              pending,
  output logic [NUM-1:0]    dirty,
  output logic              addr_err,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_sel,
  output logic [BITS-1:0]   rd_data,
  output logic [BITS-1:0]   q [NUM]
);

  state_t          state_q;
  state_t          state_d;
  logic            wr_fire;
  logic            commit;
  logic [NUM-1:0]  wr_hit;
  logic [BITS-1:0] shadow_val [NUM];
  logic [BITS-1:0] shadow_nxt [NUM];
  logic [NUM-1:0]  dirty_d;
  logic [NUM-1:0]  dirty_q;
  logic            addr_err_d;
  logic            addr_err_q;
  logic            commit_done_d;
  logic            commit_done_q;
  logic [BITS-1:0] rd_data_d;
  logic [BITS-1:0] rd_data_q;

  assign wr_fire = wr_valid && wr_ready;
  assign commit  = sync && ((state_q == ARMED) || commit_req);

  // The active cells load the shadow value as it stands after this edge's
  // write, so a write landing on the commit edge is part of the copied set.
  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_cell
      assign wr_hit[gi]     = wr_fire && (wr_addr == ADDR_W'(gi));
      assign shadow_nxt[gi] = wr_hit[gi] ? wr_data : shadow_val[gi];

      coeff_reg_cell #(.BITS(BITS)) u_shadow (
        .clk (clk),
        .rst (reset_n),
        .en  (wr_hit[gi]),
        .d   (wr_data),
        .q   (shadow_val[gi])
      );

      coeff_reg_cell #(.BITS(BITS)) u_active (
        .clk (clk),
        .rst (reset_n),
        .en  (commit),
        .d   (shadow_nxt[gi]),
        .q   (q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_req && !sync) state_d = ARMED;
      ARMED:   if (sync || commit_abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state_q == IDLE);
    pending  = (state_q == ARMED);
  end

  always_comb begin
    dirty_d = dirty_q | wr_hit;
    if (commit) begin
      dirty_d = '0;
    end

    // An accepted write that decodes to no cell is an address error; the
    // set wins over a same-cycle clear.
    addr_err_d = addr_err_q;
    if (wr_fire && !(|wr_hit)) begin
      addr_err_d = 1'b1;
    end else if (err_clr) begin
      addr_err_d = 1'b0;
    end

    commit_done_d = commit;

    rd_data_d = '0;
    for (int i = 0; i < NUM; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_data_d = rd_sel ? q[i] : shadow_val[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      dirty_q       <= '0;
      addr_err_q    <= 1'b0;
      commit_done_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      dirty_q       <= dirty_d;
      addr_err_q    <= addr_err_d;
      commit_done_q <= commit_done_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign dirty       = dirty_q;
  assign addr_err    = addr_err_q;
  assign commit_done = commit_done_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_coeff_shadow_bank.sv
// Directed bench for coeff_shadow_bank with a cycle-level reference model.
module tb_coeff_shadow_bank;

  localparam int BITS   = 32;
  localparam int NUM    = 7;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [BITS-1:0]   wr_data = '0;
  logic              commit_req = 1'b0;
  logic              commit_abort = 1'b0;
  logic              sync = 1'b0;
  logic              commit_done;
  logic              pending;
  logic [NUM-1:0]    dirty;
  logic              addr_err;
  logic              err_clr = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_sel = 1'b0;
  logic [BITS-1:0]   rd_data;
  logic [BITS-1:0]   q [NUM];

  int tests = 0;
  int fails = 0;

  coeff_shadow_bank #(.BITS(BITS), .NUM(NUM)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit_req   (commit_req),
    .commit_abort (commit_abort),
    .sync         (sync),
    .commit_done  (commit_done),
    .pending      (pending),
    .dirty        (dirty),
    .addr_err     (addr_err),
    .err_clr      (err_clr),
    .rd_addr      (rd_addr),
    .rd_sel       (rd_sel),
    .rd_data      (rd_data),
    .q            (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow/active arrays, dirty mask, armed flag.
  logic [BITS-1:0] m_sh [NUM];
  logic [BITS-1:0] m_ac [NUM];
  logic [NUM-1:0]  m_dirty;
  logic            m_armed;
  logic            m_done;
  logic            m_err;
  logic [BITS-1:0] m_rd;

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_sh[i] = '0;
      m_ac[i] = '0;
    end
    m_dirty = '0;
    m_armed = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_rd    = '0;
  endtask

  task automatic model_step();
    logic [BITS-1:0] rd_next;
    logic            accept;
    logic            fire;
    int              a;
    int              r;
    a = int'(wr_addr);
    r = int'(rd_addr);
    rd_next = '0;
    if (r < NUM) rd_next = rd_sel ? m_ac[r] : m_sh[r];
    accept = wr_valid && !m_armed;
    fire   = sync && (m_armed || commit_req);
    if (accept && a < NUM) begin
      m_sh[a]    = wr_data;
      m_dirty[a] = 1'b1;
    end
    if (accept && a >= NUM) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (fire) begin
      for (int i = 0; i < NUM; i++) m_ac[i] = m_sh[i];
      m_dirty = '0;
      m_armed = 1'b0;
    end else if (m_armed) begin
      if (commit_abort) m_armed = 1'b0;
    end else if (commit_req) begin
      m_armed = 1'b1;
    end
    m_done = fire;
    m_rd   = rd_next;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset_n);
      if (reset_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("cyc_wr_ready", wr_ready, !m_armed);
      check("cyc_pending", pending, m_armed);
      check("cyc_commit_done", commit_done, m_done);
      check("cyc_dirty", dirty, m_dirty);
      check("cyc_addr_err", addr_err, m_err);
      check("cyc_rd_data", rd_data, m_rd);
      for (int i = 0; i < NUM; i++) check($sformatf("cyc_q%0d", i), q[i], m_ac[i]);
    end
  end

  task automatic wr(input int addr, input logic [BITS-1:0] data);
    logic got;
    got = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(addr);
    wr_data  = data;
    for (int n = 0; n < 50 && !got; n++) begin
      got = wr_ready;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("wr_handshake", got, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_q0", q[0], 0);
    check("rst_dirty", dirty, 0);
    check("rst_done", commit_done, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("idle_ready", wr_ready, 1);

    // 1: fill shadow, nothing committed
    for (int i = 0; i < NUM; i++) wr(i, BITS'(32'h10 + i));
    check("t1_dirty", dirty, 7'h7F);
    check("t1_q6", q[6], 0);
    for (int i = 0; i < NUM; i++) begin
      rd_sel  = 1'b0;
      rd_addr = ADDR_W'(i);
      @(negedge clk);
      check("t1_rd_shadow", rd_data, 32'h10 + i);
      rd_sel = 1'b1;
      @(negedge clk);
      check("t1_rd_active", rd_data, 0);
    end

    // 2: armed wait then sync
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t2_pending", pending, 1);
      check("t2_ready", wr_ready, 0);
      @(negedge clk);
    end
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    for (int i = 0; i < NUM; i++) check("t2_q", q[i], 32'h10 + i);
    check("t2_dirty", dirty, 0);
    check("t2_done", commit_done, 1);
    @(negedge clk);
    check("t2_done_clear", commit_done, 0);

    // 3: write stalled while armed
    rd_sel  = 1'b0;
    rd_addr = 3'd2;
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 3'd2;
    wr_data  = 32'hDEAD;
    repeat (2) @(negedge clk);
    check("t3_stall", wr_ready, 0);
    check("t3_dirty_hold", dirty, 0);
    check("t3_rd_old", rd_data, 32'h12);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("t3_done", commit_done, 1);
    check("t3_ready", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("t3_dirty", dirty, 7'h04);
    check("t3_q2", q[2], 32'h12);
    @(negedge clk);
    check("t3_rd_new", rd_data, 32'hDEAD);

    // 4: abort, then abort racing sync
    commit_req = 1'b1;
    @(negedge clk);
    commit_req   = 1'b0;
    commit_abort = 1'b1;
    @(negedge clk);
    commit_abort = 1'b0;
    check("t4_pending", pending, 0);
    check("t4_dirty", dirty, 7'h04);
    check("t4_q2", q[2], 32'h12);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req   = 1'b0;
    commit_abort = 1'b1;
    sync         = 1'b1;
    @(negedge clk);
    commit_abort = 1'b0;
    sync         = 1'b0;
    check("t4_done", commit_done, 1);
    check("t4_q2_new", q[2], 32'hDEAD);
    check("t4_dirty_clr", dirty, 0);

    // 5: out-of-range write and error flag
    wr(7, 32'h5555);
    check("t5_err", addr_err, 1);
    check("t5_dirty", dirty, 0);
    @(negedge clk);
    check("t5_sticky", addr_err, 1);
    wr_valid = 1'b1;
    wr_addr  = 3'd7;
    err_clr  = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    check("t5_set_wins", addr_err, 1);
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_clr", addr_err, 0);
    rd_sel  = 1'b1;
    rd_addr = 3'd7;
    repeat (2) @(negedge clk);
    check("t5_rd_oob", rd_data, 0);

    // write, request and sync on one edge
    wr_valid   = 1'b1;
    wr_addr    = 3'd0;
    wr_data    = 32'hABC;
    commit_req = 1'b1;
    sync       = 1'b1;
    @(negedge clk);
    wr_valid   = 1'b0;
    commit_req = 1'b0;
    sync       = 1'b0;
    check("t5b_q0", q[0], 32'hABC);
    check("t5b_dirty", dirty, 0);
    check("t5b_done", commit_done, 1);

    // 6: reset while armed with dirty entries
    wr(1, 32'h77);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    check("t6_pending", pending, 1);
    check("t6_dirty", dirty, 7'h02);
    reset_n = 1'b1;
    #1;
    check("t6_q0", q[0], 0);
    check("t6_pend_rst", pending, 0);
    check("t6_dirty_rst", dirty, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_done_quiet", commit_done, 0);
      check("t6_pend_quiet", pending, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coeff_shadow_bank.md
Name: coeff_shadow_bank

Overview:
Double-buffered coefficient register bank: NUM shadow registers of BITS each, written through a valid/ready port, then copied atomically into NUM active registers on a sync strobe.
The active outputs feed downstream datapaths (filters, scalers), which never see a partially updated coefficient set.
Successor to the single-stage enabled register bank. Adds a handshake write port, shadow/active staging, sync-aligned commit with abort, a dirty mask, readback and address-error flagging.

Parameters:
BITS, 32, width of each coefficient register
NUM, 7, number of coefficient registers (≥1)
ADDR_W, $clog2(NUM) (min 1), address width, derived; not overridden

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous reset, ACTIVE-HIGH despite name: reset_n==1 resets
wr_valid  in  1  write request
wr_ready  out  1  bank can accept a write
wr_addr  in  ADDR_W  shadow register index
wr_data  in  BITS  write data
commit_req  in  1  request shadow→active copy (sampled, level ok)
commit_abort  in  1  cancel pending commit
sync  in  1  commit-allowed strobe (frame boundary)
commit_done  out  1  one-cycle pulse after active set updated
pending  out  1  commit armed, waiting for sync
dirty  out  NUM  shadow[i] written since last commit
addr_err  out  1  sticky: write to address ≥ NUM accepted
err_clr  in  1  clears addr_err
rd_addr  in  ADDR_W  readback index
rd_sel  in  1  0 = shadow, 1 = active
rd_data  out  BITS  registered readback
q  out  BITS x [NUM]  unpacked array of active coefficients

Behaviour:
- Reset (async, reset_n==1):
  - q, shadow, rd_data all 0; dirty=0; addr_err=0; commit_done=0.
  - State IDLE. Any pending commit is lost.
- States:
  - IDLE: wr_ready=1, pending=0.
  - ARMED: wr_ready=0, pending=1.
- Write: accepted on an edge with wr_valid && wr_ready.
  - addr < NUM: shadow[addr]<=wr_data and dirty[addr]<=1 on that edge.
  - addr ≥ NUM: write consumed, no shadow change, addr_err<=1.
  - wr_valid in ARMED is stalled, not dropped; the master holds it.
- Commit fires on an edge when sync==1 and either state==ARMED or (state==IDLE && commit_req).
  - All q[i]<=shadow[i] simultaneously; dirty<=0; state→IDLE.
  - commit_done=1 for exactly the next cycle.
- IDLE && commit_req && !sync → ARMED.
- ARMED && commit_abort && !sync → IDLE. No copy; shadow and dirty retained.
- ARMED && commit_abort && sync same edge: commit wins.
- IDLE write + commit_req same edge: write is included in the shadow copied by that or a later commit. If sync is also high, the new data IS copied, and the write's dirty bit is cleared in the same edge.
- commit_req while ARMED: ignored (already armed). A commit with dirty==0 still copies and pulses commit_done.
- addr_err: set has priority over err_clr in the same cycle.
- Readback: rd_data updates 1 cycle after rd_addr/rd_sel.
  - Active readback returns the pre-commit value on the commit edge.
  - rd_addr ≥ NUM returns 0.
- Latency: write→shadow 1 cycle; sync edge→q 0 cycles (registered at that edge); commit_done the cycle after.
- q changes only on commit edges or reset.

Decomposition:
- Package coeff_pkg:
  - state enum {IDLE, ARMED}.
  - Function addr_w(num) returning max(1,$clog2(num)).
- Sub-module coeff_reg_cell(BITS): one register with async active-high clear, load enable, data in/out.
  - Instantiated 2×NUM via generate: shadow cells loaded by decoded write, active cells loaded by commit.

Test Plan:
1. Reset, then write addr 0..6 with data 0x10+i, no commit -> q all 0, dirty=0x7F, shadow readback 0x10+i, active readback 0.
2. commit_req with sync low 3 cycles then sync pulse -> pending=1 and wr_ready=0 during wait. On sync edge q[i]=0x10+i, dirty=0, commit_done pulses exactly 1 cycle.
3. Write during ARMED (addr 2, 0xDEAD) -> stalled until commit completes, then accepted. q[2] keeps 0x12; shadow[2]=0xDEAD; dirty=0x04.
4. commit_req then commit_abort before sync -> back to IDLE, q unchanged, dirty unchanged. Abort+sync same cycle -> commit occurs.
5. Write addr 7 with NUM=7 -> wr_ready handshake completes, addr_err=1 sticky, no dirty bit set. err_clr -> addr_err=0.
6. Assert reset_n mid-ARMED with dirty≠0 -> immediately q=0, pending=0, dirty=0, commit_done stays 0 after release.
